clk_period_meter: RTL

//  Measures the period of a slow, asynchronous square/tick signal in units of clk cycles.
//  It is the receive-side counterpart of the lab clock dividers: it recovers the divide ratio they produce.
//  It sits between a divided-clock source (or an external pin) and the display/debug logic.

---
 rtl/clk_meas_pkg.sv | 14 +
 rtl/sig_sync_edge.sv | 30 +++
 rtl/clk_period_meter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
// Holds the counter width, timeout default and FSM state encoding.
package clk_meas_pkg;

  localparam int CNT_W_DEF   = 27;
  localparam int TIMEOUT_DEF = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchroniser plus history flop with rising-edge detect.
// Ports: clk, rst_n, sig_i (async in), lvl_o (synced level), edge_o.
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic lvl_o,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow async signal in clk cycles, with lock/timeout.
// Ports: clk, rst_n, sig_in, en -> period, period_vld, locked, timeout
// and high_cnt when CLK_METER_HIGH_TIME_EN is defined.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             timeout
`ifdef CLK_METER_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_cnt
`endif
);

  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic s2;
  logic edge_w;

  sig_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (sig_in),
    .lvl_o  (s2),
    .edge_o (edge_w)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             locked_q, locked_d;
  logic             to_q, to_d;
  logic             at_to;

`ifdef CLK_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
`else
  logic unused_s2;
  assign unused_s2 = s2;
`endif

  assign at_to = (cnt_q == TO_M1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = 1'b0;
    locked_d = locked_q;
    to_d     = to_q;
`ifdef CLK_METER_HIGH_TIME_EN
    hcnt_d   = hcnt_q;
    high_d   = high_q;
`endif
    if (!en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
`ifdef CLK_METER_HIGH_TIME_EN
      hcnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          // ARM keeps counting so a dead input still raises timeout
          if (edge_w) begin
            cnt_d   = '0;
            state_d = ST_MEAS;
`ifdef CLK_METER_HIGH_TIME_EN
            hcnt_d  = '0;
`endif
          end else if (at_to) begin
            to_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_MEAS: begin
          // edge takes priority over timeout on the same cycle
          if (edge_w) begin
            period_d = cnt_q + ONE;
            vld_d    = 1'b1;
            cnt_d    = '0;
            locked_d = 1'b1;
            to_d     = 1'b0;
`ifdef CLK_METER_HIGH_TIME_EN
            // the edge cycle itself is high
            high_d   = hcnt_q + ONE;
            hcnt_d   = '0;
`endif
          end else if (at_to) begin
            to_d     = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_ARM;
`ifdef CLK_METER_HIGH_TIME_EN
            hcnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
`ifdef CLK_METER_HIGH_TIME_EN
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s2};
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
`ifdef CLK_METER_HIGH_TIME_EN
      hcnt_q   <= '0;
      high_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      to_q     <= to_d;
`ifdef CLK_METER_HIGH_TIME_EN
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
`endif
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign timeout    = to_q;
`ifdef CLK_METER_HIGH_TIME_EN
  assign high_cnt   = high_q;
`endif

endmodule
